// File: rtl/psk_costas_dispatcher.sv
// PSK Costas dispatcher: internal I/Q NCO, windowed 1-bit correlators, phase loop and lock FSM.
// Optional macro PSK_FREQ_LOOP_EN adds a clamped frequency-tracking loop on top of the phase loop.
module psk_costas_dispatcher #(
    parameter int              ACC_W    = 12,
    parameter int              CORR_W   = 8,
    parameter int              WIN_LEN  = 127,
    parameter logic [ACC_W-1:0] FCW_INIT = 12'h100,
    parameter logic [ACC_W-1:0] PSTEP    = 12'h100,
    parameter int              LOCK_THR = 64,
    parameter int              LOCK_CNT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     sig,
    output logic                     stb,
    output logic signed [CORR_W-1:0] i_value,
    output logic signed [CORR_W-1:0] q_value,
    output logic                     data_bit,
    output logic [1:0]               quadrant,
    output logic                     locked,
    output logic [ACC_W-1:0]         pcw_out,
    output logic [ACC_W-1:0]         fcw_out
);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    localparam int CNT_W = $clog2(WIN_LEN + 1);
    localparam int QC_W  = $clog2(LOCK_CNT + 1);
    localparam logic [ACC_W-1:0]         QOFF   = {2'b01, {(ACC_W-2){1'b0}}};
    localparam logic signed [CORR_W-1:0] ONE    = 1;
    localparam logic [CORR_W-1:0]        THR_HI = CORR_W'(LOCK_THR);
    localparam logic [CORR_W-1:0]        THR_LO = CORR_W'(LOCK_THR / 2);

    state_t                     state;
    logic [ACC_W-1:0]           ph;
    logic [ACC_W-1:0]           pcw;
    logic [ACC_W-1:0]           fcw;
    logic [CNT_W-1:0]           cnt;
    logic [QC_W-1:0]            qcnt;
    logic signed [CORR_W-1:0]   acc_i;
    logic signed [CORR_W-1:0]   acc_q;

    logic [ACC_W-1:0]           ph_i;
    logic [ACC_W-1:0]           ph_q;
    logic signed [CORR_W-1:0]   acc_i_nx;
    logic signed [CORR_W-1:0]   acc_q_nx;
    logic                       i_neg;
    logic                       q_neg;
    logic [CORR_W-1:0]          i_mag;
    logic                       win_end;
    logic                       pcw_up;

    // Carrier codes are the MSBs of the shifted phase; the correlators fold in this cycle's sample.
    always_comb begin
        ph_i     = ph + pcw;
        ph_q     = ph_i + QOFF;
        acc_i_nx = (sig == ph_i[ACC_W-1]) ? acc_i + ONE : acc_i - ONE;
        acc_q_nx = (sig == ph_q[ACC_W-1]) ? acc_q + ONE : acc_q - ONE;
        i_neg    = acc_i_nx[CORR_W-1];
        q_neg    = acc_q_nx[CORR_W-1];
        i_mag    = i_neg ? -acc_i_nx : acc_i_nx;
        win_end  = (cnt == CNT_W'(WIN_LEN - 1));
        pcw_up   = (i_neg == q_neg);
    end

    // Window sequencing, result capture, phase loop and lock qualification share one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ph       <= '0;
            pcw      <= '0;
            cnt      <= '0;
            qcnt     <= '0;
            acc_i    <= '0;
            acc_q    <= '0;
            stb      <= 1'b0;
            i_value  <= '0;
            q_value  <= '0;
            data_bit <= 1'b0;
            quadrant <= 2'b00;
            locked   <= 1'b0;
        end else if (!en) begin
            state  <= IDLE;
            cnt    <= '0;
            qcnt   <= '0;
            acc_i  <= '0;
            acc_q  <= '0;
            stb    <= 1'b0;
            locked <= 1'b0;
        end else begin
            ph  <= ph + fcw;
            stb <= 1'b0;
            if (state == IDLE)
                state <= TRACK;
            if (win_end) begin
                cnt      <= '0;
                acc_i    <= '0;
                acc_q    <= '0;
                stb      <= 1'b1;
                i_value  <= acc_i_nx;
                q_value  <= acc_q_nx;
                data_bit <= ~i_neg;
                quadrant <= {q_neg, i_neg};
                if (state != IDLE) begin
                    pcw <= pcw_up ? pcw + PSTEP : pcw - PSTEP;
                    // Lock entry needs strong windows; release uses half the threshold for hysteresis.
                    if (state == TRACK) begin
                        if (i_mag >= THR_HI) begin
                            if (qcnt == QC_W'(LOCK_CNT - 1)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                qcnt   <= '0;
                            end else begin
                                qcnt <= qcnt + 1'b1;
                            end
                        end else begin
                            qcnt <= '0;
                        end
                    end else begin
                        if (i_mag < THR_LO) begin
                            if (qcnt == QC_W'(LOCK_CNT - 1)) begin
                                state  <= TRACK;
                                locked <= 1'b0;
                                qcnt   <= '0;
                            end else begin
                                qcnt <= qcnt + 1'b1;
                            end
                        end else begin
                            qcnt <= '0;
                        end
                    end
                end
            end else begin
                cnt   <= cnt + 1'b1;
                acc_i <= acc_i_nx;
                acc_q <= acc_q_nx;
            end
        end
    end

`ifdef PSK_FREQ_LOOP_EN
    localparam logic [ACC_W-1:0] FCW_SPAN = FCW_INIT >> 3;
    localparam logic [ACC_W-1:0] FCW_MAX  = FCW_INIT + FCW_SPAN;
    localparam logic [ACC_W-1:0] FCW_MIN  = FCW_INIT - FCW_SPAN;

    // Frequency nudges follow the phase-step direction while tracking, clamped around FCW_INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcw <= FCW_INIT;
        end else if (en && win_end && state == TRACK) begin
            if (pcw_up) begin
                if (fcw < FCW_MAX)
                    fcw <= fcw + 1'b1;
            end else begin
                if (fcw > FCW_MIN)
                    fcw <= fcw - 1'b1;
            end
        end
    end
`else
    assign fcw = FCW_INIT;
`endif

    assign pcw_out = pcw;
    assign fcw_out = fcw;

endmodule
